// File: rtl/hilo_unit.sv
// HI/LO register pair and issue sequencer for the external multiply/divide core.
// It latches operands, holds md_en for the core latency, then writes the result back into HI/LO.
module hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    input  logic             flush,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    output logic             md_en,
    output logic [3:0]       md_op,
    output logic [WIDTH-1:0] md_a,
    output logic [WIDTH-1:0] md_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_DIV   = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_legal;
    logic             op_div;
    logic             accept;
    logic             move_ok;
    logic             wb_fire;

    // Issue qualification: a divide by zero is refused outright so HI/LO keep their values.
    always_comb begin
        op_legal = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MULTU) || (op == OP_DIVU);
        op_div   = op[0];
        accept   = (state == IDLE) && start && !flush && op_legal &&
                   !(op_div && (rt_val == '0));
        move_ok  = (state == IDLE) && !start && !flush;
        wb_fire  = (state == WB) && !flush;
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            RUN: begin
                if (cnt == '0) state_nxt = WB;
                else           cnt_nxt   = cnt - 1'b1;
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Core operand ordering: a is the divisor for divides, b the dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_op <= '0;
            md_a  <= '0;
            md_b  <= '0;
        end else if (accept) begin
            md_op <= op;
            md_a  <= op_div ? rt_val : rs_val;
            md_b  <= op_div ? rs_val : rt_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (wb_fire) begin
            hi <= md_hi;
            lo <= md_lo;
        end else if (move_ok) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= wb_fire;
    end

    // NOTE: md_en decodes the state register directly, so reset drops it without waiting for a clock.
    assign busy  = (state != IDLE);
    assign md_en = busy;
    assign stall = busy & (start | mthi | mtlo | mf_req);

endmodule

// File: tb/tb_hilo_unit.sv
// Randomised scoreboard bench for hilo_unit with a behavioural multiply/divide core.
// Expected HI/LO come from plain 64-bit arithmetic on the issued rs/rt operands.
module tb_hilo_unit;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 6;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_DIV   = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val, rt_val;
    logic             mthi, mtlo;
    logic [WIDTH-1:0] wdata;
    logic             mf_req;
    logic             flush;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             md_en;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] md_a, md_b;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, stall, done;

    hilo_unit #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .mf_req(mf_req), .flush(flush),
        .md_hi(md_hi), .md_lo(md_lo), .md_en(md_en), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    res_t        exp_q[$];
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural result of an instruction, from rs/rt.
    function automatic res_t ref_calc(input logic [3:0] o, input logic [31:0] rs, input logic [31:0] rt);
        res_t            r;
        longint          sp;
        longint unsigned up;
        int              q, m;
        r = '0;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(rs)) * longint'($signed(rt));
                r.hi = sp[63:32]; r.lo = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'b0, rs} * {32'b0, rt};
                r.hi = up[63:32]; r.lo = up[31:0];
            end
            OP_DIV: begin
                q = $signed(rs) / $signed(rt);
                m = $signed(rs) % $signed(rt);
                r.hi = m; r.lo = q;
            end
            OP_DIVU: begin
                r.hi = rs % rt; r.lo = rs / rt;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural core: a = divisor / multiplicand, b = dividend / multiplier.
    function automatic res_t core_calc(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
        res_t               r;
        logic signed [63:0] ea, eb, prod;
        r  = '0;
        ea = m[3] ? {32'b0, a} : {{32{a[31]}}, a};
        eb = m[3] ? {32'b0, b} : {{32{b[31]}}, b};
        if (m[0]) begin
            if (a != 0) begin
                if (m[3]) begin
                    r.lo = b / a; r.hi = b % a;
                end else begin
                    r.lo = 32'($signed(b) / $signed(a));
                    r.hi = 32'($signed(b) % $signed(a));
                end
            end
        end else begin
            prod = ea * eb;
            r.hi = prod[63:32]; r.lo = prod[31:0];
        end
        return r;
    endfunction

    // The core output is only meaningful once en has been held for LATENCY edges.
    int   en_cnt;
    res_t core_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     en_cnt <= 0;
        else if (md_en) en_cnt <= en_cnt + 1;
        else            en_cnt <= 0;
    end
    assign core_r = core_calc(md_op, md_a, md_b);
    assign md_hi  = (md_en && en_cnt >= LATENCY) ? core_r.hi : 32'hDEAD_BEEF;
    assign md_lo  = (md_en && en_cnt >= LATENCY) ? core_r.lo : 32'hBAAD_F00D;

    // Scoreboard monitor: every done pulse must match the oldest pending result.
    res_t mon_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("mon_hi", hi, mon_e.hi);
                check("mon_lo", lo, mon_e.lo);
            end
        end
    end

    // Issue one start at a negedge and follow it until busy drops.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a_rs, input logic [31:0] b_rt,
                         input int flush_at, input bit mf, input bit mv);
        bit   legal, acc;
        res_t e;
        int   n_busy, exp_busy;
        legal  = (o == OP_MULT) || (o == OP_DIV) || (o == OP_MULTU) || (o == OP_DIVU);
        acc    = legal && !(o[0] && b_rt == 0);
        start  = 1'b1; op = o; rs_val = a_rs; rt_val = b_rt;
        if (mv) begin mthi = 1'b1; wdata = $urandom; end
        @(negedge clk);
        start  = 1'b0; mthi = 1'b0;
        op     = 4'($urandom); rs_val = $urandom; rt_val = $urandom;
        if (acc && flush_at < 0) begin
            e = ref_calc(o, a_rs, b_rt);
            exp_q.push_back(e);
            exp_hi = e.hi; exp_lo = e.lo;
        end
        n_busy = 0;
        for (int c = 0; c < 4 * LATENCY; c++) begin
            if (!busy) break;
            n_busy++;
            if (c == 1) begin
                check("md_op", md_op, o);
                check("md_a", md_a, o[0] ? b_rt : a_rs);
                check("md_b", md_b, o[0] ? a_rs : b_rt);
                check("md_en_run", md_en, 1);
                if (!mf) begin
                    mtlo = 1'b1; wdata = $urandom;
                    #1 check("stall_mv", stall, 1);
                end
            end
            if (mf && c >= 3) begin
                mf_req = 1'b1;
                #1 check("stall_mf", stall, 1);
            end
            if (c == flush_at) flush = 1'b1;
            @(negedge clk);
            flush = 1'b0; mtlo = 1'b0;
        end
        exp_busy = !acc ? 0 : (flush_at >= 0 ? flush_at + 1 : LATENCY + 1);
        check("busy_cycles", n_busy, exp_busy);
        check("done", done, acc && flush_at < 0);
        check("md_en_idle", md_en, 0);
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        if (mf) begin
            #1 check("stall_done", stall, 0);
            mf_req = 1'b0;
        end
    endtask

    task automatic do_mv(input bit h, input bit l, input logic [31:0] d);
        mthi = h; mtlo = l; wdata = d;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        check("mv_hi", hi, exp_hi);
        check("mv_lo", lo, exp_lo);
        check("mv_busy", busy, 0);
    endtask

    task automatic rand_step();
        int          k, fa;
        logic [3:0]  o;
        logic [31:0] a, b;
        bit          mv;
        k  = $urandom_range(0, 11);
        a  = $urandom;
        b  = $urandom;
        fa = -1;
        if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40)) - 32'd20;
        if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40)) - 32'd20;
        case (k)
            0, 1:    o = OP_MULT;
            2, 3:    o = OP_MULTU;
            4, 5:    o = OP_DIV;
            6, 7:    o = OP_DIVU;
            8:       o = 4'($urandom_range(2, 7));
            10: begin o = $urandom_range(0, 1) ? OP_DIV : OP_DIVU; b = '0; end
            default: o = $urandom_range(0, 1) ? OP_MULT : OP_DIVU;
        endcase
        if (k == 11) fa = $urandom_range(0, LATENCY);
        if (o[0] && b == 0 && k != 10) b = 32'd3;
        if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        if (k == 9) begin
            do_mv(1'($urandom), 1'($urandom), $urandom);
        end else begin
            mv = (k < 8) && ($urandom_range(0, 3) == 0);
            do_op(o, a, b, fa, $urandom_range(0, 2) == 0, mv);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; mf_req = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_md_en", md_en, 0);
        check("rst_md_op", md_op, 0);
        check("rst_md_a", md_a, 0);
        check("rst_md_b", md_b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, 0, 0);
        check("tp_mult_hi", hi, 32'hFFFF_FFFF);
        check("tp_mult_lo", lo, 32'hFFFF_FFEB);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, 0, 0);
        check("tp_multu_hi", hi, 32'h0000_0001);
        check("tp_multu_lo", lo, 32'hFFFF_FFFE);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1, 0);
        check("tp_div_hi", hi, 32'hFFFF_FFFF);
        check("tp_div_lo", lo, 32'hFFFF_FFFD);
        do_op(OP_DIVU, 32'd100, 32'd0, -1, 0, 0);
        do_mv(1'b0, 1'b1, 32'h0000_1234);
        check("tp_mtlo", lo, 32'h0000_1234);
        check("tp_mtlo_hi", hi, 32'hFFFF_FFFF);
        do_op(OP_MULT, 32'd5, 32'd6, 2, 0, 0);
        do_op(OP_DIV, 32'd9, 32'd4, LATENCY, 0, 0);
        do_op(4'b0110, 32'd1, 32'd2, -1, 0, 0);
        do_op(OP_MULTU, 32'd3, 32'd4, -1, 0, 1);
        do_mv(1'b1, 1'b1, 32'hCAFE_0001);

        for (int i = 0; i < 60; i++) rand_step();

        // Asynchronous reset in the middle of an operation.
        do_mv(1'b1, 1'b1, 32'hA5A5_5A5A);
        start = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; mf_req = 1'b1;
        @(negedge clk);
        #1 check("pre_rst_stall", stall, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_md_en", md_en, 0);
        check("arst_md_op", md_op, 0);
        check("arst_md_a", md_a, 0);
        check("arst_md_b", md_b, 0);
        check("arst_busy", busy, 0);
        check("arst_stall", stall, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1; mf_req = 1'b0; exp_hi = '0; exp_lo = '0;
        do_op(OP_MULT, 32'd12, 32'hFFFF_FFFE, -1, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
